// File: rtl/regfile_dbg_access_pkg.sv
// regfile_dbg_access_pkg
// Shared definitions for the register-file debug access block: command
// opcodes, the controller state enumeration and the address/data widths.
// Optional feature macro: REGFILE_DBG_CHECKSUM_EN adds the CSUM state.
package regfile_dbg_access_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_DUMP  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HALT,
        READ,
        RESP,
        WRITE
`ifdef REGFILE_DBG_CHECKSUM_EN
        ,
        CSUM
`endif
    } state_t;

endpackage

// File: rtl/regfile_dbg_access.sv
// regfile_dbg_access
// Debug access port to the core register file. A host issues READ, WRITE or
// DUMP commands; each register access waits until the core is halted, then
// uses the register file's read port (rf_a1/rf_rd1) or write port
// (rf_we/rf_a3/rf_wd). Every word is returned on a valid/ready response
// channel with its address, a last flag and an error flag.
//
// Optional feature: define REGFILE_DBG_CHECKSUM_EN to append an XOR checksum
// word (rsp_addr = 0, rsp_last = 1) after the register words of a DUMP.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cpu_halted            core stalled; register file port may be used
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                0 READ, 1 WRITE, 2 DUMP, 3 reserved (error)
//   cmd_addr              start register
//   cmd_cnt               DUMP word count minus one
//   cmd_wdata             WRITE data
//   rf_a1 / rf_rd1        register file read address / combinational data
//   rf_we, rf_a3, rf_wd   register file write port
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_addr    response word and its register address
//   rsp_last, rsp_err     final word of a command / command rejected
module regfile_dbg_access
    import regfile_dbg_access_pkg::*;
#(
    parameter int REGISTER_DEPTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_halted,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W-1:0]   cmd_cnt,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic [ADDR_W-1:0]   rf_a1,
    input  logic [DATA_W-1:0]   rf_rd1,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_a3,
    output logic [DATA_W-1:0]   rf_wd,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [ADDR_W-1:0]   rsp_addr,
    output logic                rsp_last,
    output logic                rsp_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REGISTER_DEPTH - 1);

    state_t              state;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   rem_q;      // DUMP words still to send after the current one
    logic [DATA_W-1:0]   wdata_q;
`ifdef REGFILE_DBG_CHECKSUM_EN
    logic [DATA_W-1:0]   csum;
`endif

    logic                addr_ok;
    logic [ADDR_W-1:0]   next_addr;
    logic                more_words;

    assign addr_ok    = (int'(addr_q) < REGISTER_DEPTH);
    // DUMP walks the register file circularly, wrapping at the top register.
    assign next_addr  = (addr_q == LAST_ADDR) ? '0 : addr_q + 5'd1;
    assign more_words = (op_q == OP_DUMP) && !rsp_err && (rem_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            op_q      <= OP_READ;
            addr_q    <= '0;
            rem_q     <= '0;
            wdata_q   <= '0;
            rf_a1     <= '0;
            rf_we     <= 1'b0;
            rf_a3     <= '0;
            rf_wd     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
`ifdef REGFILE_DBG_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        addr_q    <= cmd_addr;
                        // Only DUMP uses the count; single-word ops finish after one response.
                        rem_q     <= (cmd_op == OP_DUMP) ? cmd_cnt : '0;
                        wdata_q   <= cmd_wdata;
                        cmd_ready <= 1'b0;
`ifdef REGFILE_DBG_CHECKSUM_EN
                        csum      <= '0;
`endif
                        state     <= WAIT_HALT;
                    end
                end

                WAIT_HALT: begin
                    if (cpu_halted) begin
                        if ((op_q == OP_RSVD) || !addr_ok) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_addr  <= addr_q;
                            rsp_last  <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else if (op_q == OP_WRITE) begin
                            // x0 is hardwired to zero: acknowledge but never write it.
                            rf_we <= (addr_q != '0);
                            rf_a3 <= addr_q;
                            rf_wd <= wdata_q;
                            state <= WRITE;
                        end else begin
                            rf_a1 <= addr_q;
                            state <= READ;
                        end
                    end
                end

                READ: begin
                    rf_a1     <= '0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= rf_rd1;
                    rsp_addr  <= addr_q;
                    rsp_err   <= 1'b0;
`ifdef REGFILE_DBG_CHECKSUM_EN
                    // The checksum word, not the final register word, closes a DUMP.
                    rsp_last  <= (op_q != OP_DUMP);
                    csum      <= csum ^ rf_rd1;
`else
                    rsp_last  <= (rem_q == '0);
`endif
                    state     <= RESP;
                end

                WRITE: begin
                    rf_we     <= 1'b0;
                    rf_a3     <= '0;
                    rf_wd     <= '0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= wdata_q;
                    rsp_addr  <= addr_q;
                    rsp_last  <= 1'b1;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        if (more_words) begin
                            rsp_valid <= 1'b0;
                            rem_q     <= rem_q - 5'd1;
                            addr_q    <= next_addr;
                            state     <= WAIT_HALT;
`ifdef REGFILE_DBG_CHECKSUM_EN
                        end else if ((op_q == OP_DUMP) && !rsp_err) begin
                            // Present the checksum back-to-back with the last register word.
                            rsp_data  <= csum;
                            rsp_addr  <= '0;
                            rsp_last  <= 1'b1;
                            state     <= CSUM;
`endif
                        end else begin
                            rsp_valid <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

`ifdef REGFILE_DBG_CHECKSUM_EN
                CSUM: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
`endif

                default: begin
                    rsp_valid <= 1'b0;
                    rf_we     <= 1'b0;
                    rf_a1     <= '0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_access.sv
// tb_regfile_dbg_access
// Bench for regfile_dbg_access: a behavioural register file answers the
// DUT's ports, a reference model predicts the response stream and write
// pulses of each command, and a negedge process compares against it.
module tb_regfile_dbg_access;
    import regfile_dbg_access_pkg::*;

`ifdef REGFILE_DBG_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_halted;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [4:0]  cmd_cnt;
    logic [31:0] cmd_wdata;
    logic [4:0]  rf_a1;
    logic [31:0] rf_rd1;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_addr;
    logic        rsp_last;
    logic        rsp_err;

    always #5 clk = ~clk;

    regfile_dbg_access #(.REGISTER_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .cpu_halted(cpu_halted),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_cnt(cmd_cnt), .cmd_wdata(cmd_wdata),
        .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    // Environment register file (x0 reads as zero).
    logic [31:0] mem [32];
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : mem[rf_a1];
    always @(posedge clk) if (rf_we && rf_a3 != 5'd0) mem[rf_a3] <= rf_wd;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 | (32'(i) << 8) | 32'(i) | (32'(i) << 19);
    endfunction

    // Reference model state.
    typedef struct { logic [31:0] data; logic [4:0] addr; logic last; logic err; } rsp_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    rsp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [31:0] ref_rf [32];

    logic [4:0]  got_addr_q[$];
    logic [31:0] got_data_q[$];
    logic [31:0] last_data;
    logic [4:0]  last_addr;
    logic        last_last;
    logic        last_err;
    int          a1_cycles;
    logic [4:0]  last_a1;
    int          we_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_err",  32'(rsp_err),  32'(exp_q[0].err));
                    chk("rsp_last", 32'(rsp_last), 32'(exp_q[0].last));
                    if (!exp_q[0].err) begin
                        chk("rsp_data", rsp_data, exp_q[0].data);
                        chk("rsp_addr", 32'(rsp_addr), 32'(exp_q[0].addr));
                    end
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        got_addr_q.push_back(rsp_addr);
                        got_data_q.push_back(rsp_data);
                        last_data = rsp_data;
                        last_addr = rsp_addr;
                        last_last = rsp_last;
                        last_err  = rsp_err;
                    end
                end
            end
            if (rf_we) begin
                we_cycles++;
                if (wr_q.size() == 0) begin
                    chk("rf_we_unexpected", 32'(rf_we), 32'd0);
                end else begin
                    chk("rf_a3", 32'(rf_a3), 32'(wr_q[0].a));
                    chk("rf_wd", rf_wd, wr_q[0].d);
                    void'(wr_q.pop_front());
                end
            end
            if (rf_a1 != 5'd0) begin
                a1_cycles++;
                last_a1 = rf_a1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 300) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, 32'(n < 300), 32'd1);
        chk({name, "_wr_pending"}, 32'(wr_q.size()), 32'd0);
    endtask

    // Predict the command's effects, then present it for one accepting edge.
    task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [4:0] cnt,
                        input logic [31:0] wd);
        rsp_t        r;
        wr_t         w;
        logic [31:0] x;
        logic [4:0]  a;
        int          n = 0;
        got_addr_q.delete();
        got_data_q.delete();
        a1_cycles = 0;
        we_cycles = 0;
        case (op)
            OP_READ: begin
                r = '{ref_rf[addr], addr, 1'b1, 1'b0};
                exp_q.push_back(r);
            end
            OP_WRITE: begin
                if (addr != 5'd0) begin
                    w = '{addr, wd};
                    wr_q.push_back(w);
                    ref_rf[addr] = wd;
                end
                r = '{wd, addr, 1'b1, 1'b0};
                exp_q.push_back(r);
            end
            OP_DUMP: begin
                x = 32'd0;
                for (int i = 0; i <= int'(cnt); i++) begin
                    a = 5'((int'(addr) + i) % 32);
                    r = '{ref_rf[a], a, (i == int'(cnt)) && (CS == 0), 1'b0};
                    exp_q.push_back(r);
                    x = x ^ ref_rf[a];
                end
                if (CS == 1) begin
                    r = '{x, 5'd0, 1'b1, 1'b0};
                    exp_q.push_back(r);
                end
            end
            default: begin
                r = '{32'd0, addr, 1'b1, 1'b1};
                exp_q.push_back(r);
            end
        endcase
        while (!cmd_ready && n < 300) begin
            step();
            n++;
        end
        chk("cmd_ready_timeout", 32'(n < 300), 32'd1);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_cnt   = cnt;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  rsp_data, 32'd0);
        chk({tag, "_rsp_addr"},  32'(rsp_addr), 32'd0);
        chk({tag, "_rsp_last"},  32'(rsp_last), 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_rf_we"},     32'(rf_we), 32'd0);
        chk({tag, "_rf_a1"},     32'(rf_a1), 32'd0);
        chk({tag, "_rf_a3"},     32'(rf_a3), 32'd0);
        chk({tag, "_rf_wd"},     rf_wd, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) begin
            mem[i]    = init_val(i);
            ref_rf[i] = (i == 0) ? 32'd0 : init_val(i);
        end
        reset      = 1'b1;
        cpu_halted = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_addr   = 5'd0;
        cmd_cnt    = 5'd0;
        cmd_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        a1_cycles  = 0;
        we_cycles  = 0;
        last_data  = 32'd0;
        last_addr  = 5'd0;
        last_last  = 1'b0;
        last_err   = 1'b0;
        last_a1    = 5'd0;
        repeat (3) step();
        check_reset_vals("rst");
        reset      = 1'b0;
        cpu_halted = 1'b1;
        rsp_ready  = 1'b1;
        step();

        // WRITE x5 then read it back.
        send(OP_WRITE, 5'd5, 5'd0, 32'hDEAD_BEEF);
        wait_idle("write5");
        chk("write5_we_pulses", 32'(we_cycles), 32'd1);
        chk("write5_data", last_data, 32'hDEAD_BEEF);
        chk("write5_last", 32'(last_last), 32'd1);
        chk("write5_err",  32'(last_err), 32'd0);

        send(OP_READ, 5'd5, 5'd0, 32'd0);
        wait_idle("read5");
        chk("read5_a1_cycles", 32'(a1_cycles), 32'd1);
        chk("read5_a1", 32'(last_a1), 32'd5);
        chk("read5_data", last_data, 32'hDEAD_BEEF);
        chk("read5_addr", 32'(last_addr), 32'd5);

        // DUMP with address wrap through x0.
        send(OP_DUMP, 5'd30, 5'd3, 32'd0);
        wait_idle("dump30");
        chk("dump30_words", 32'(got_addr_q.size()), 32'(4 + CS));
        if (got_addr_q.size() >= 4) begin
            chk("dump30_a0", 32'(got_addr_q[0]), 32'd30);
            chk("dump30_a1", 32'(got_addr_q[1]), 32'd31);
            chk("dump30_a2", 32'(got_addr_q[2]), 32'd0);
            chk("dump30_a3", 32'(got_addr_q[3]), 32'd1);
            chk("dump30_x0_data", got_data_q[2], 32'd0);
            chk("dump30_a30_data", got_data_q[0], 32'hA5F0_1E1E);
        end
        if (got_addr_q.size() == 5) begin
            chk("dump30_csum", got_data_q[4],
                got_data_q[0] ^ got_data_q[1] ^ got_data_q[2] ^ got_data_q[3]);
        end

        // DUMP with response backpressure and a halt drop between words.
        send(OP_DUMP, 5'd8, 5'd7, 32'd0);
        n = 0;
        while (!(got_addr_q.size() == 2 && rsp_valid) && n < 200) begin
            step();
            n++;
        end
        chk("stall_reach_w2", 32'(n < 200), 32'd1);
        rsp_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_w2_held", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        n = 0;
        while (got_addr_q.size() < 5 && n < 200) begin
            step();
            n++;
        end
        chk("stall_reach_w4", 32'(n < 200), 32'd1);
        cpu_halted = 1'b0;
        repeat (4) begin
            step();
            chk("halt_pause_no_rsp", 32'(rsp_valid), 32'd0);
            chk("halt_pause_no_read", 32'(rf_a1), 32'd0);
        end
        cpu_halted = 1'b1;
        wait_idle("dump8");
        chk("dump8_words", 32'(got_addr_q.size()), 32'(8 + CS));
        if (got_addr_q.size() >= 8) begin
            for (int i = 0; i < 8; i++)
                chk("dump8_order", 32'(got_addr_q[i]), 32'(8 + i));
        end

        // WRITE to x0: acknowledged, never written.
        send(OP_WRITE, 5'd0, 5'd0, 32'h1234_5678);
        wait_idle("write0");
        chk("write0_we_pulses", 32'(we_cycles), 32'd0);
        chk("write0_err", 32'(last_err), 32'd0);

        // Reserved op: error response, no write.
        send(OP_RSVD, 5'd3, 5'd0, 32'h5555_AAAA);
        wait_idle("rsvd");
        chk("rsvd_err", 32'(last_err), 32'd1);
        chk("rsvd_we_pulses", 32'(we_cycles), 32'd0);

        // Reset while DUMP word 3 is being offered.
        send(OP_DUMP, 5'd0, 5'd7, 32'd0);
        n = 0;
        while (!(got_addr_q.size() == 3 && rsp_valid) && n < 200) begin
            step();
            n++;
        end
        chk("rst_reach_w3", 32'(n < 200), 32'd1);
        rsp_ready = 1'b0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        exp_q.delete();
        wr_q.delete();
        check_reset_vals("midrst");
        rsp_ready = 1'b1;

        // Port usable again after the abort.
        send(OP_READ, 5'd5, 5'd0, 32'd0);
        wait_idle("read5_after_rst");
        chk("read5_after_rst_data", last_data, 32'hDEAD_BEEF);

        send(OP_DUMP, 5'd31, 5'd1, 32'd0);
        wait_idle("dump31");
        chk("dump31_words", 32'(got_addr_q.size()), 32'(2 + CS));
        chk("dump31_last", 32'(last_last), 32'd1);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
